writer: RTL

Output-side 4-phase handshake engine for the stream cipher. It accepts single-cycle byte pulses from the internal datapath (cipher output and hash digest bytes) and buffers them in a small FIFO. It presents each byte on the chip output pins using a request/acknowledge 4-phase handshake with the external host. It is the transmit counterpart of the input `reader`, which turns host handshakes into internal pulses.

---
 rtl/writer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/writer.sv
// writer: transmit-side 4-phase handshake engine.
// Datapath bytes arrive as single-cycle pulses and are queued in a small
// FIFO of {tag, byte} entries. Each entry is then offered to the host with
// a request/acknowledge handshake: raise request, wait for ack high, drop
// request, wait for ack low. The host acknowledge pin is asynchronous and
// is brought into the clock domain through a two-flop synchronizer.
module writer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] out_byte_in,
  input  logic       out_is_hash_in,
  input  logic       out_byte_pulse,
  input  logic       output_ack,
  output logic [7:0] output_byte,
  output logic       output_is_hash,
  output logic       output_request,
  output logic       fifo_full,
  output logic       overflow,
  output logic       writer_idle
);

  // Pointer width covers DEPTH entries; the count needs one extra bit so
  // that "full" (count == DEPTH) is distinguishable from "empty".
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Handshake FSM encoding.
  localparam logic [1:0] W_IDLE = 2'b00;
  localparam logic [1:0] W_REQ  = 2'b01;
  localparam logic [1:0] W_WAIT = 2'b10;

  // Synchronizer flops for the host acknowledge pin.
  logic          ack_meta_r;
  logic          ack_s_r;

  // Handshake FSM.
  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;

  // FIFO storage and bookkeeping.
  logic [8:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [8:0]    head_s;

  // Per-cycle FIFO events.
  logic          push_s;
  logic          pop_s;
  logic          drop_s;

  // Two-flop synchronizer: the FSM only ever looks at ack_s_r.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_meta_r <= 1'b0;
      ack_s_r    <= 1'b0;
    end else begin
      ack_meta_r <= output_ack;
      ack_s_r    <= ack_meta_r;
    end
  end

  // Decode pop/push/drop for this cycle. A pop only happens from W_IDLE with
  // a non-empty FIFO and the host ack low; a push at full is still accepted
  // when a pop frees the head slot in the same cycle.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if ((state_r == W_IDLE) && (count_r != CNT_ZERO) && !ack_s_r) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (out_byte_pulse && ((count_r != CNT_FULL) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (out_byte_pulse && !push_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Handshake sequencing: load in W_IDLE, wait for ack high in W_REQ,
  // wait for ack low in W_WAIT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      W_IDLE: begin
        if (pop_s) begin
          state_nxt_s = W_REQ;
        end else begin
          state_nxt_s = W_IDLE;
        end
      end
      W_REQ: begin
        if (ack_s_r) begin
          state_nxt_s = W_WAIT;
        end else begin
          state_nxt_s = W_REQ;
        end
      end
      W_WAIT: begin
        if (!ack_s_r) begin
          state_nxt_s = W_IDLE;
        end else begin
          state_nxt_s = W_WAIT;
        end
      end
      default: begin
        state_nxt_s = W_IDLE;
      end
    endcase
  end

  assign head_s = mem_r[rd_ptr_r];

  // FIFO entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 9'h000;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {out_is_hash_in, out_byte_in};
    end
  end

  // FIFO pointers (natural wrap, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= W_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output data registers: loaded only when an entry is popped, held
  // otherwise so the host sees stable data for the whole handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      output_byte    <= 8'h00;
      output_is_hash <= 1'b0;
    end else if (pop_s) begin
      output_byte    <= head_s[7:0];
      output_is_hash <= head_s[8];
    end
  end

  // Request is high exactly while the FSM sits in W_REQ.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      output_request <= 1'b0;
    end else begin
      output_request <= (state_nxt_s == W_REQ);
    end
  end

  // Sticky overflow: set on the edge that discards a byte.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end
  end

  assign fifo_full   = (count_r == CNT_FULL);
  assign writer_idle = (state_r == W_IDLE) && (count_r == CNT_ZERO);

endmodule
